mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester and the EX-stage data requester. It sits between the pipeline's inst/data SRAM-like interfaces and the single downstream port, such as the bridge or unified SRAM. It serializes transactions with one outstanding transaction at a time, and arbitrates round-robin when both requesters are pending. It routes address- and data-phase handshakes back to the owning requester.

## Interface
Parameters:
- none; all widths are fixed, with 32-bit address and data.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- inst_req  in  1  fetch read request; held with inst_addr until inst_addr_ok
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch address accepted by the memory
- inst_data_ok  out  1  fetch read data valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request; held with all data_* fields until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data read complete or write acknowledged
- data_rdata  out  32  data read data
- mem_req, mem_wr, mem_size[1:0], mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  out  downstream request
- mem_addr_ok, mem_data_ok  in  1  downstream handshakes
- mem_rdata  in  32  downstream read data
- busy  out  1  arbiter is not in IDLE

## Operation
- Registers:
  - state: IDLE / ADDR / DATA.
  - owner: INST / DATA.
  - last_owner: reset value INST, so DATA wins the first tie.
- IDLE:
  - If exactly one request is pending, owner ← that requester.
  - If both are pending, owner ← the requester that is not last_owner.
  - On a grant, go to ADDR.
  - With no request, stay in IDLE.
- ADDR:
  - mem_req = 1.
  - mem_* fields are driven combinationally from the owner's live inputs.
  - INST owner drives mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0.
  - On mem_addr_ok: pulse owner's *_addr_ok for that cycle and go to DATA.
- DATA:
  - mem_req = 0.
  - On mem_data_ok: pulse owner's *_data_ok for that cycle, set last_owner ← owner, and go to IDLE.
- The non-owner's addr_ok and data_ok are always 0.
- inst_rdata = data_rdata = mem_rdata. They are meaningful only with the respective data_ok.
- Writes complete through data_data_ok, exactly like reads.
- In IDLE, mem_req = 0 and all mem_* fields are 0.

## Timing
- Reset: state = IDLE, owner = INST, last_owner = INST. All outputs are 0, busy = 0.
- Arbitration latency is 1 cycle. A request seen in IDLE at edge N drives mem_req from cycle N+1.
- Minimum transaction takes 3 cycles (IDLE→ADDR→DATA→IDLE), with addr_ok and data_ok each arriving in their first eligible cycle.
- The next grant can be made in the IDLE cycle following data_ok. Back-to-back throughput is 1 transaction per 3 cycles.
- mem_req stays asserted with stable fields until mem_addr_ok. The requester must hold its inputs. Dropping the request in ADDR is a protocol violation and its behaviour is unspecified.
- mem_data_ok in IDLE or ADDR is ignored. mem_addr_ok outside ADDR is ignored.
- A new request arriving while busy waits; no request is lost because requesters hold them.
- Reset mid-transaction returns to IDLE next edge. The outstanding response is discarded, and the downstream port is reset concurrently.
- busy = (state != IDLE).

## Test plan
- Single fetch to addr 0x1C000000:
  - mem_addr_ok and mem_data_ok are each 1 cycle late; mem_rdata = 0x02800C0C.
  - Required: inst_addr_ok pulse, then inst_data_ok with inst_rdata = 0x02800C0C.
  - Required: data_* handshakes stay 0 and busy falls after data_ok.
- Data write:
  - Stimulus: addr 0x1C0100F0, wdata 0xDEADBEEF, wstrb 0xF, size 2.
  - Required: mem_wr = 1 and fields match exactly; data_data_ok pulses once; inst outputs stay silent.
- Simultaneous inst_req and data_req right after reset:
  - Required: DATA is granted first, then INST is granted in the following IDLE.
  - Required: on a repeated tie, grants alternate DATA, INST, DATA, INST.
- Backpressure:
  - Stimulus: hold mem_addr_ok = 0 for 5 cycles.
  - Required: mem_req and mem_addr stay constant throughout; no addr_ok is pulsed to either requester.
- Spurious handshakes:
  - Stimulus: mem_data_ok pulsed in IDLE and in ADDR.
  - Required: no data_ok reaches either requester and the state is unchanged.
- Reset in DATA state:
  - Stimulus: reset asserted while in DATA.
  - Required: IDLE with all outputs 0 next cycle; a fresh inst request afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one SRAM-like port between fetch and data
module mem_port_arbiter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  owner_t last_owner, last_owner_nxt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      owner      <= OWN_INST;
      last_owner <= OWN_INST;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    mem_req        = 1'b0;
    mem_wr         = 1'b0;
    mem_size       = 2'd0;
    mem_wstrb      = 4'd0;
    mem_addr       = 32'd0;
    mem_wdata      = 32'd0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    data_addr_ok   = 1'b0;
    data_data_ok   = 1'b0;

    case (state)
      S_IDLE: begin
        // On a tie the requester that did not finish last wins.
        if (inst_req && data_req) begin
          owner_nxt = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
          state_nxt = S_ADDR;
        end else if (data_req) begin
          owner_nxt = OWN_DATA;
          state_nxt = S_ADDR;
        end else if (inst_req) begin
          owner_nxt = OWN_INST;
          state_nxt = S_ADDR;
        end
      end

      S_ADDR: begin
        mem_req = 1'b1;
        if (owner == OWN_DATA) begin
          mem_wr    = data_wr;
          mem_size  = data_size;
          mem_wstrb = data_wstrb;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
        end else begin
          mem_size  = 2'd2;
          mem_addr  = inst_addr;
        end
        if (mem_addr_ok) begin
          inst_addr_ok = (owner == OWN_INST);
          data_addr_ok = (owner == OWN_DATA);
          state_nxt    = S_DATA;
        end
      end

      S_DATA: begin
        if (mem_data_ok) begin
          inst_data_ok   = (owner == OWN_INST);
          data_data_ok   = (owner == OWN_DATA);
          last_owner_nxt = owner;
          state_nxt      = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic m_last;  // 0 = fetch finished last, 1 = data finished last

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: a lone requester wins; on a tie the one that did not finish last wins.
  function automatic logic arb(input logic ip, input logic dp, input logic last);
    if (ip && dp) return !last;
    return dp;
  endfunction

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_req"},   32'(mem_req), 32'd0);
    chk({tag, "_ctrl"},  32'({mem_wr, mem_size, mem_wstrb}), 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_hs"},    32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_rdata"}, inst_rdata | data_rdata, 32'd0);
  endtask

  task automatic chk_addr_phase(input logic own, input logic aok);
    chk("a_req",  32'(mem_req), 32'd1);
    chk("a_busy", 32'(busy), 32'd1);
    if (own) begin
      chk("a_ctrl",  32'({mem_wr, mem_size, mem_wstrb}), 32'({data_wr, data_size, data_wstrb}));
      chk("a_addr",  mem_addr, data_addr);
      chk("a_wdata", mem_wdata, data_wdata);
    end else begin
      chk("a_ctrl",  32'({mem_wr, mem_size, mem_wstrb}), 32'({1'b0, 2'd2, 4'd0}));
      chk("a_addr",  mem_addr, inst_addr);
      chk("a_wdata", mem_wdata, 32'd0);
    end
    chk("a_inst_aok", 32'(inst_addr_ok), 32'(aok && !own));
    chk("a_data_aok", 32'(data_addr_ok), 32'(aok && own));
    chk("a_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
  endtask

  // Entered just after a negedge with the arbiter in IDLE and requests already driven.
  task automatic serve(input int alat, input int dlat, input logic [31:0] rdata, input bit spur);
    logic own;
    own = arb(inst_req, data_req, m_last);
    #1;
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    for (int i = 0; i < alat; i++) begin
      mem_data_ok = spur;
      #1;
      chk_addr_phase(own, 1'b0);
      @(negedge clk);
      mem_data_ok = 1'b0;
    end
    mem_addr_ok = 1'b1;
    #1;
    chk_addr_phase(own, 1'b1);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    if (own) data_req = 1'b0; else inst_req = 1'b0;
    for (int i = 0; i < dlat; i++) begin
      mem_addr_ok = spur;
      #1;
      chk("d_req", 32'(mem_req), 32'd0);
      chk("d_busy", 32'(busy), 32'd1);
      chk("d_hs", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
      @(negedge clk);
      mem_addr_ok = 1'b0;
    end
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    #1;
    chk("d_inst_dok", 32'(inst_data_ok), 32'(!own));
    chk("d_data_dok", 32'(data_data_ok), 32'(own));
    chk("d_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("d_rdata", own ? data_rdata : inst_rdata, rdata);
    @(negedge clk);
    mem_data_ok = 1'b0;
    m_last = own;
    #1;
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all_quiet("rst");
    resetn = 1'b1;
    m_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic new_data_req();
    data_req   = 1'b1;
    data_wr    = 1'($urandom_range(0, 1));
    data_size  = 2'($urandom_range(0, 2));
    data_wstrb = 4'($urandom);
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  initial begin
    do_reset();

    // Single fetch, handshakes one cycle late.
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    serve(1, 1, 32'h0280_0C0C, 1'b0);

    // Data write.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h1C01_00F0; data_wdata = 32'hDEAD_BEEF;
    serve(0, 0, 32'h1234_5678, 1'b0);

    // Ties after reset alternate DATA, INST, DATA, INST.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!inst_req) begin inst_req = 1'b1; inst_addr = $urandom; end
      if (!data_req) new_data_req();
      chk("tie_pred", 32'(arb(inst_req, data_req, m_last)), 32'(i % 2 == 0));
      serve(0, 0, $urandom, 1'b0);
    end
    inst_req = 1'b0; data_req = 1'b0;

    // Backpressure with spurious data_ok during ADDR and spurious addr_ok during DATA.
    inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    serve(5, 2, 32'hCAFE_F00D, 1'b1);

    // Spurious handshakes while IDLE.
    mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
    #1;
    chk("spur_idle_hs", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    #1;
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_req", 32'(mem_req), 32'd0);

    // Reset while in DATA; last_owner must return to INST.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_wstrb = 4'd0;
    data_addr = 32'h0000_0100; data_wdata = 32'd0;
    serve(0, 0, 32'h0BAD_0BAD, 1'b0);
    inst_req = 1'b1; inst_addr = 32'h1C00_0080;
    @(negedge clk);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0; inst_req = 1'b0;
    #1;
    chk("rd_busy", 32'(busy), 32'd1);
    mem_rdata = 32'd0;
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk_all_quiet("rst_data");
    resetn = 1'b1;
    m_last = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0080;
    new_data_req();
    chk("rst_tie_pred", 32'(arb(inst_req, data_req, m_last)), 32'd1);
    serve(0, 0, 32'h1111_2222, 1'b0);
    serve(1, 0, 32'h3333_4444, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      if (!inst_req && $urandom_range(0, 1) == 1) begin inst_req = 1'b1; inst_addr = $urandom; end
      if (!data_req && $urandom_range(0, 1) == 1) new_data_req();
      if (!inst_req && !data_req) begin inst_req = 1'b1; inst_addr = $urandom; end
      serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
